pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It takes hazard and cache-status inputs and generates:
- the PC write enable;
- the IF/ID stall, flush and bubble controls;
- the ID/EX bubble;
- the back-end freeze.

It tracks an outstanding instruction-cache miss so that a taken branch resolved during the miss squashes the stale fetch when the fill completes. It also keeps saturating stall and flush performance counters.

## Interface
- CNT_W, 32, width of each performance counter
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- icache_stall_i  in  1  I-cache miss outstanding; fetched instruction invalid this cycle
- dcache_stall_i  in  1  D-cache miss in MEM; whole pipeline must freeze
- ld_use_i  in  1  ID instruction depends on a load currently in EX
- branch_taken_i  in  1  branch in ID resolved taken; target is on the PC mux
- clr_cnt_i  in  1  synchronous clear of both counters
- pc_write_o  out  1  PC register load enable
- if_id_stall_o  out  1  IF/ID hold
- if_id_flush_o  out  1  IF/ID load zeros
- imembubble_o  out  1  IF/ID bubble marker for the fetched slot
- id_ex_bubble_o  out  1  ID/EX loads a NOP
- back_stall_o  out  1  ID/EX, EX/MEM and MEM/WB hold
- state_o  out  2  FSM state: 0 RUN, 1 IMISS, 2 KILL
- stall_cnt_o  out  CNT_W  cycles with pc_write_o=0
- flush_cnt_o  out  CNT_W  cycles with if_id_flush_o=1

## Operation
- Control outputs are combinational from the current state and inputs. State and counters are registered.
- Per-cycle priority is d > lu > br > i, where d=dcache_stall_i, lu=ld_use_i, br=branch_taken_i and i=icache_stall_i.
  - **d=1 (freeze):**
    - back_stall_o=1, if_id_stall_o=1, pc_write_o=0.
    - if_id_flush_o, id_ex_bubble_o and imembubble_o are all 0.
    - br is ignored; it remains asserted because ID is frozen and is honored after the freeze.
  - **lu=1, d=0:**
    - pc_write_o=0, if_id_stall_o=1, id_ex_bubble_o=1.
    - br is ignored.
  - **br=1, lu=0, d=0:** pc_write_o=1, if_id_flush_o=1.
  - **i=1, br=0, lu=0, d=0:** pc_write_o=0, imembubble_o=1, so IF/ID captures a bubble.
  - **Otherwise (normal):**
    - State RUN or IMISS: pc_write_o=1, all other controls 0.
    - State KILL: pc_write_o=0 and if_id_flush_o=1. The delivered instruction is from the pre-branch path; the PC already holds the target.
- FSM transitions, evaluated at posedge:
  - Any state, i=0 → RUN. This consumes KILL even when d, lu or br is active, because the stale fetch is either not captured or is flushed.
  - i=1, d=0, lu=0, br=1 → KILL.
  - i=1, d=0, lu=0, br=0: RUN → IMISS; IMISS and KILL hold.
  - i=1 with d=1 or lu=1: state holds.
- Counters:
  - stall_cnt_o increments when pc_write_o=0; flush_cnt_o increments when if_id_flush_o=1.
  - Both saturate at 2^CNT_W−1 with no wrap.
  - clr_cnt_i=1 sets both to 0 and takes priority over increment in the same cycle.

## Timing
- While rst_i=0:
  - state RUN, both counters 0.
  - pc_write_o, if_id_stall_o, if_id_flush_o, imembubble_o, id_ex_bubble_o and back_stall_o are all forced to 0.
  - state_o=0.
- The first posedge after rst_i rises operates normally.
- Control outputs respond in the same cycle as their inputs, with zero latency, and take effect at the next posedge in the pipeline registers.
- Taken-branch penalty is 1 bubble with no miss. With a miss, it is the miss duration plus 1 flushed slot.
- Load-use costs 1 cycle per asserted cycle.
- Counter outputs reflect events one cycle later (registered).
- Reset asserted mid-KILL returns to RUN immediately (asynchronous); no kill is remembered.

## Test plan
- **Reset:** hold rst_i=0 with all inputs 1 → every control output 0, state_o=0, counters 0. Release rst_i → the first clocked cycle follows the priority rules.
- **Priority, lu over br:** assert lu=1 and br=1 for 1 cycle → pc_write_o=0, if_id_stall_o=1, id_ex_bubble_o=1, if_id_flush_o=0. stall_cnt_o rises 0→1 the next cycle; flush_cnt_o stays 0.
- **Branch during miss:**
  - i=1 in RUN for 1 cycle → IMISS.
  - Then br=1, i=1 → pc_write_o=1, if_id_flush_o=1, state_o=2.
  - Next i=1 for 3 cycles → imembubble_o=1, pc_write_o=0.
  - Then i=0 → if_id_flush_o=1, pc_write_o=0, state_o=0.
  - Result: flush_cnt_o=2, stall_cnt_o=5.
- **Freeze over KILL:**
  - In KILL, d=1 for 4 cycles with i=1 → back_stall_o=1, if_id_stall_o=1, state_o stays 2.
  - Then i=0 with d=1 → next state RUN and no flush.
- **Saturation:** CNT_W=4, hold lu=1 for 20 cycles → stall_cnt_o=15. Then clr_cnt_i=1 with lu=1 → stall_cnt_o=0 the next cycle.
- **Back-to-back branches:** br=1 for 2 cycles, i=0 → pc_write_o=1 and if_id_flush_o=1 both cycles, flush_cnt_o=2, state_o stays 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Resolves data-cache freezes, load-use stalls, taken branches and I-cache
// misses into per-stage hold/flush/bubble controls. It remembers a taken
// branch resolved during an outstanding I-cache miss so the stale fetch is
// squashed when the fill completes. It also keeps saturating stall and flush
// event counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             icache_stall_i,
  input  logic             dcache_stall_i,
  input  logic             ld_use_i,
  input  logic             branch_taken_i,
  input  logic             clr_cnt_i,
  output logic             pc_write_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             imembubble_o,
  output logic             id_ex_bubble_o,
  output logic             back_stall_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  // RUN: no miss pending. IMISS: fetch miss outstanding.
  // KILL: miss outstanding, and the line being filled is on the pre-branch path.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_IMISS = 2'd1,
    ST_KILL  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // State register; asynchronous reset drops any remembered kill.
  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_i) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a completed fill always returns to RUN. Otherwise a
  // freeze or load-use holds, and an unhindered branch taken during the
  // miss marks the pending fetch for killing.
  always_comb begin
    state_d = state_q;
    if (!icache_stall_i) begin
      state_d = ST_RUN;
    end else if (dcache_stall_i || ld_use_i) begin
      state_d = state_q;
    end else if (branch_taken_i) begin
      state_d = ST_KILL;
    end else begin
      case (state_q)
        ST_RUN:  state_d = ST_IMISS;
        ST_IMISS: state_d = ST_IMISS;
        ST_KILL: state_d = ST_KILL;
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Control outputs: fixed priority freeze > load-use > branch > I-miss,
  // then the KILL squash of the stale fetch. All controls are off in reset.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    pc_write_o     = 1'b0;
    if_id_stall_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    imembubble_o   = 1'b0;
    id_ex_bubble_o = 1'b0;
    back_stall_o   = 1'b0;
    if (rst_i) begin
      if (dcache_stall_i) begin
        back_stall_o  = 1'b1;
        if_id_stall_o = 1'b1;
      end else if (ld_use_i) begin
        if_id_stall_o  = 1'b1;
        id_ex_bubble_o = 1'b1;
      end else if (branch_taken_i) begin
        pc_write_o    = 1'b1;
        if_id_flush_o = 1'b1;
      end else if (icache_stall_i) begin
        imembubble_o = 1'b1;
      end else if (state_q == ST_KILL) begin
        if_id_flush_o = 1'b1;
      end else begin
        pc_write_o = 1'b1;
      end
    end
  end

  // Saturating event counters; clear wins over increment.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (clr_cnt_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_write_o && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (if_id_flush_o && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: reset checks, a table of
// single-cycle vectors, hand-written multi-cycle sequences and a randomized
// run against a behavioural model of miss/kill bookkeeping.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             icache_stall_i = 1'b1;
  logic             dcache_stall_i = 1'b1;
  logic             ld_use_i = 1'b1;
  logic             branch_taken_i = 1'b1;
  logic             clr_cnt_i = 1'b1;
  logic             pc_write_o;
  logic             if_id_stall_o;
  logic             if_id_flush_o;
  logic             imembubble_o;
  logic             id_ex_bubble_o;
  logic             back_stall_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .icache_stall_i (icache_stall_i),
    .dcache_stall_i (dcache_stall_i),
    .ld_use_i       (ld_use_i),
    .branch_taken_i (branch_taken_i),
    .clr_cnt_i      (clr_cnt_i),
    .pc_write_o     (pc_write_o),
    .if_id_stall_o  (if_id_stall_o),
    .if_id_flush_o  (if_id_flush_o),
    .imembubble_o   (imembubble_o),
    .id_ex_bubble_o (id_ex_bubble_o),
    .back_stall_o   (back_stall_o),
    .state_o        (state_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Control bundle order: {pc_write, if_id_stall, if_id_flush, imembubble,
  // id_ex_bubble, back_stall}.
  localparam logic [5:0] C_RUN    = 6'b100000;
  localparam logic [5:0] C_FREEZE = 6'b010001;
  localparam logic [5:0] C_LDUSE  = 6'b010010;
  localparam logic [5:0] C_BRANCH = 6'b101000;
  localparam logic [5:0] C_MISS   = 6'b000100;
  localparam logic [5:0] C_KILL   = 6'b001000;

  typedef struct {
    logic       d, lu, br, i, clr;
    logic [5:0] ctrl;
    logic [1:0] nstate;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Model: a miss may be outstanding, and a kill may be owed on its fill.
  bit m_miss;
  bit m_kill;
  int m_stall;
  int m_flush;
  logic [5:0] last_ctrl;

  function automatic logic [1:0] model_state();
    return m_kill ? 2'd2 : (m_miss ? 2'd1 : 2'd0);
  endfunction

  function automatic logic [5:0] model_ctrl(logic d, logic lu, logic br, logic i);
    if (d)      return C_FREEZE;
    if (lu)     return C_LDUSE;
    if (br)     return C_BRANCH;
    if (i)      return C_MISS;
    if (m_kill) return C_KILL;
    return C_RUN;
  endfunction

  task automatic model_reset();
    m_miss  = 1'b0;
    m_kill  = 1'b0;
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Settles the current inputs, compares against the model, advances the
  // model, then steps past the next rising edge.
  task automatic eval();
    logic [5:0] exp;
    #1;
    last_ctrl = {pc_write_o, if_id_stall_o, if_id_flush_o, imembubble_o,
                 id_ex_bubble_o, back_stall_o};
    exp = model_ctrl(dcache_stall_i, ld_use_i, branch_taken_i, icache_stall_i);
    check("model_ctrl", 32'(last_ctrl), 32'(exp));
    check("model_state", 32'(state_o), 32'(model_state()));
    check("model_stall_cnt", 32'(stall_cnt_o), 32'(m_stall));
    check("model_flush_cnt", 32'(flush_cnt_o), 32'(m_flush));
    if (clr_cnt_i) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (!exp[5] && m_stall < CMAX) m_stall++;
      if (exp[3]  && m_flush < CMAX) m_flush++;
    end
    if (!icache_stall_i) begin
      m_miss = 1'b0;
      m_kill = 1'b0;
    end else if (!dcache_stall_i && !ld_use_i) begin
      m_miss = 1'b1;
      if (branch_taken_i) m_kill = 1'b1;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic cycle(input logic d, input logic lu, input logic br,
                       input logic i, input logic clr);
    @(negedge clk_i);
    dcache_stall_i = d;
    ld_use_i       = lu;
    branch_taken_i = br;
    icache_stall_i = i;
    clr_cnt_i      = clr;
    eval();
  endtask

  vec_t vecs[16];

  initial begin
    //            d    lu   br   i    clr  ctrl      next state
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, C_RUN,    2'd0};
    vecs[1]  = '{1'b0,1'b1,1'b1,1'b0,1'b0, C_LDUSE,  2'd0};
    vecs[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, C_BRANCH, 2'd0};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, C_MISS,   2'd1};
    vecs[4]  = '{1'b1,1'b0,1'b1,1'b1,1'b0, C_FREEZE, 2'd1};
    vecs[5]  = '{1'b0,1'b1,1'b0,1'b1,1'b0, C_LDUSE,  2'd1};
    vecs[6]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, C_BRANCH, 2'd2};
    vecs[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, C_MISS,   2'd2};
    vecs[8]  = '{1'b0,1'b1,1'b0,1'b1,1'b0, C_LDUSE,  2'd2};
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, C_KILL,   2'd0};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b1,1'b0, C_MISS,   2'd1};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0, C_RUN,    2'd0};
    vecs[12] = '{1'b0,1'b0,1'b1,1'b1,1'b0, C_BRANCH, 2'd2};
    vecs[13] = '{1'b0,1'b0,1'b1,1'b0,1'b0, C_BRANCH, 2'd0};
    vecs[14] = '{1'b1,1'b1,1'b1,1'b1,1'b0, C_FREEZE, 2'd0};
    vecs[15] = '{1'b0,1'b0,1'b0,1'b0,1'b1, C_RUN,    2'd0};

    model_reset();

    // Reset with every input high: all controls off, state and counters 0.
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    check("rst_ctrl", 32'({pc_write_o, if_id_stall_o, if_id_flush_o, imembubble_o,
                           id_ex_bubble_o, back_stall_o}), 32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
    check("rst_flush_cnt", 32'(flush_cnt_o), 32'd0);

    // Release: first clocked cycle (inputs still all 1) is a freeze.
    rst_i = 1'b1;
    eval();
    check("post_rst_ctrl", 32'(last_ctrl), 32'(C_FREEZE));
    check("post_rst_state", 32'(state_o), 32'd0);

    // Load-use outranks branch.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("lu_br_ctrl", 32'(last_ctrl), 32'(C_LDUSE));
    check("lu_br_stall_cnt", 32'(stall_cnt_o), 32'd1);
    check("lu_br_flush_cnt", 32'(flush_cnt_o), 32'd0);

    // Table of single-cycle vectors starting from RUN.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    foreach (vecs[k]) begin
      cycle(vecs[k].d, vecs[k].lu, vecs[k].br, vecs[k].i, vecs[k].clr);
      check($sformatf("vec%0d_ctrl", k), 32'(last_ctrl), 32'(vecs[k].ctrl));
      check($sformatf("vec%0d_state", k), 32'(state_o), 32'(vecs[k].nstate));
    end

    // Branch resolved during a miss.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("bm_imiss_state", 32'(state_o), 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("bm_br_ctrl", 32'(last_ctrl), 32'(C_BRANCH));
    check("bm_kill_state", 32'(state_o), 32'd2);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("bm_fill_ctrl", 32'(last_ctrl), 32'(C_MISS));
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("bm_squash_ctrl", 32'(last_ctrl), 32'(C_KILL));
    check("bm_run_state", 32'(state_o), 32'd0);
    check("bm_flush_cnt", 32'(flush_cnt_o), 32'd2);
    check("bm_stall_cnt", 32'(stall_cnt_o), 32'd5);

    // Freeze over KILL: the fill completing under a freeze drops the kill.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      check("fk_ctrl", 32'(last_ctrl), 32'(C_FREEZE));
      check("fk_state", 32'(state_o), 32'd2);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fk_exit_ctrl", 32'(last_ctrl), 32'(C_FREEZE));
    check("fk_exit_state", 32'(state_o), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fk_no_flush", 32'(last_ctrl), 32'(C_RUN));
    check("fk_flush_cnt", 32'(flush_cnt_o), 32'd1);

    // Saturation, then clear beats increment.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (20) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("sat_stall_cnt", 32'(stall_cnt_o), 32'(CMAX));
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("clr_stall_cnt", 32'(stall_cnt_o), 32'd0);

    // Back-to-back branches without a miss.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("b2b_ctrl", 32'(last_ctrl), 32'(C_BRANCH));
      check("b2b_state", 32'(state_o), 32'd0);
    end
    check("b2b_flush_cnt", 32'(flush_cnt_o), 32'd2);

    // Asynchronous reset in the middle of KILL.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("ar_kill_state", 32'(state_o), 32'd2);
    #2;
    rst_i = 1'b0;
    #1;
    check("ar_state", 32'(state_o), 32'd0);
    check("ar_ctrl", 32'({pc_write_o, if_id_stall_o, if_id_flush_o, imembubble_o,
                          id_ex_bubble_o, back_stall_o}), 32'd0);
    check("ar_flush_cnt", 32'(flush_cnt_o), 32'd0);
    @(negedge clk_i);
    model_reset();
    icache_stall_i = 1'b0;
    branch_taken_i = 1'b0;
    rst_i = 1'b1;
    eval();
    check("ar_after_ctrl", 32'(last_ctrl), 32'(C_RUN));

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
